// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and io_bus: byte/half/word/double loads with
// extension, read-modify-write for sub-double stores. Optional fault checks: LSU_FAULT_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [0:11] req_addr,
    input  logic [0:63] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:63] resp_data,
    output logic        resp_fault,
    output logic [0:8]  bus_addr,
    output logic [0:63] bus_write_data,
    output logic        bus_write_enable,
    input  logic [0:63] bus_read_data,
    output logic [2:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is high only in IDLE; resp_valid is high only in RESP and the response
    // (data and fault) is held stable until resp_ready completes the transfer.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        op_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;

    logic        accept;
    logic        req_fault;
    logic [2:0]  req_off;
    logic [2:0]  req_low_mask;
    logic [2:0]  eff_off;

    logic [63:0] rd_word;
    logic [3:0]  end_byte;
    logic [3:0]  shift_bytes;
    logic [5:0]  shift_bits;
    logic [63:0] field;
    logic [63:0] data_mask;
    logic [63:0] load_val;
    logic [63:0] merged;

    assign accept  = req_valid && req_ready;
    assign req_off = req_addr[9:11];

    always_comb begin
        case (req_size)
            2'd0:    req_low_mask = 3'b000;
            2'd1:    req_low_mask = 3'b001;
            2'd2:    req_low_mask = 3'b011;
            default: req_low_mask = 3'b111;
        endcase
    end

`ifdef LSU_FAULT_EN
    logic fault_q;
    logic misaligned;

    assign misaligned = |(req_off & req_low_mask);
    // ex space (word address LSB clear) is read-only
    assign req_fault  = misaligned || (req_op && !req_addr[8]);
    assign eff_off    = req_off;
    assign resp_fault = fault_q && (state_q == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault_q <= 1'b0;
        else if (accept) fault_q <= req_fault;
    end
`else
    assign req_fault  = 1'b0;
    assign eff_off    = req_off & ~req_low_mask;
    assign resp_fault = 1'b0;
`endif

    // Byte 0 is the most significant byte, so the selected lane sits
    // (8 - offset - n) bytes above the numeric LSB.
    assign rd_word     = bus_read_data;
    assign end_byte    = {1'b0, off_q} + (4'd1 << size_q);
    assign shift_bytes = 4'd8 - end_byte;
    assign shift_bits  = {shift_bytes[2:0], 3'b000};
    assign field       = rd_word >> shift_bits;

    always_comb begin
        data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        load_val  = field;
        case (size_q)
            2'd0: begin
                data_mask = 64'h0000_0000_0000_00FF;
                load_val  = {{56{signed_q & field[7]}}, field[7:0]};
            end
            2'd1: begin
                data_mask = 64'h0000_0000_0000_FFFF;
                load_val  = {{48{signed_q & field[15]}}, field[15:0]};
            end
            2'd2: begin
                data_mask = 64'h0000_0000_FFFF_FFFF;
                load_val  = {{32{signed_q & field[31]}}, field[31:0]};
            end
            default: begin
                data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                load_val  = field;
            end
        endcase
    end

    assign merged = (rd_word & ~(data_mask << shift_bits)) |
                    ((wdata_q & data_mask) << shift_bits);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_fault)           state_d = RESP;
                    else if (!req_op)        state_d = RD_ADDR;
                    else if (req_size == 2'd3) state_d = WR;
                    else                     state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = op_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q           <= 1'b0;
            size_q         <= 2'd0;
            signed_q       <= 1'b0;
            off_q          <= 3'd0;
            wdata_q        <= 64'd0;
            bus_addr       <= 9'd0;
            bus_write_data <= 64'd0;
            resp_data      <= 64'd0;
        end else if (accept) begin
            op_q      <= req_op;
            size_q    <= req_size;
            signed_q  <= req_signed;
            off_q     <= eff_off;
            wdata_q   <= req_wdata;
            resp_data <= 64'd0;
            if (!req_fault) begin
                bus_addr <= req_addr[0:8];
                if (req_op && req_size == 2'd3) bus_write_data <= req_wdata;
            end
        end else if (state_q == RD_DATA) begin
            if (op_q) bus_write_data <= merged;
            else      resp_data      <= load_val;
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = (state_q == RESP);
    assign bus_write_enable = (state_q == WR);
    assign fsm_state        = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the execute stage and `io_bus`. Accepts one load/store request at a time over a valid/ready handshake and drives the bus `addr`/`write_data`/`write_enable`. Captures `read_data` and returns a result over a second valid/ready handshake. Handles byte/half/word/double sizes: loads use extraction plus sign/zero extension; sub-double stores use read-modify-write.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — high only in IDLE.
- `req_op`  in  1  — 0 = load, 1 = store.
- `req_size`  in  2  — 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_signed`  in  1  — sign-extend loads.
- `req_addr`  in  [0:11]  — bits [0:8] are the 64-bit word address (bit 8 = 1 selects memory, 0 selects ex space); bits [9:11] are the byte offset.
- `req_wdata`  in  [0:63]  — store data, right-justified.
- `resp_valid`  out  1  — result present.
- `resp_ready`  in  1  — consumer accepts the result.
- `resp_data`  out  [0:63]  — load result; 0 for stores and faults.
- `resp_fault`  out  1  — request faulted.
- `bus_addr`  out  [0:8]  — to `io_bus` addr.
- `bus_write_data`  out  [0:63]  — to `io_bus` write_data.
- `bus_write_enable`  out  1  — to `io_bus` write_enable.
- `bus_read_data`  in  [0:63]  — from `io_bus` read_data.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- Request acceptance:
  - A request is accepted when `req_valid` and `req_ready` are both high.
  - Op, size, signed, addr and wdata are registered on acceptance.
  - `bus_addr` is loaded with `req_addr[0:8]`.
- Transitions out of IDLE on acceptance:
  - Fault → RESP.
  - Load → RD_ADDR.
  - Double store → WR.
  - Sub-double store → RD_ADDR.
- Read and write path:
  - RD_ADDR → RD_DATA unconditionally.
  - At the end of RD_DATA the FSM samples `bus_read_data` into the word register.
  - From RD_DATA, loads go to RESP and stores go to WR.
  - WR drives `bus_write_enable` = 1 for exactly one cycle, then → RESP.
- RESP: `resp_valid` = 1; the FSM holds until `resp_ready`, then → IDLE.
- Byte numbering: byte k occupies bits [8k:8k+7]; n = 1/2/4/8 bytes for size 0/1/2/3.
- Load extraction:
  - Bytes offset..offset+n-1 are placed in `resp_data[64-8n:63]`.
  - Upper bits are zero-filled, or filled with the extracted MSB when `req_signed` = 1.
- Store merge:
  - Bytes offset..offset+n-1 of the read word are replaced by bytes from `req_wdata[64-8n:63]`.
  - All other bytes keep the read value.
  - The merged word drives `bus_write_data` in WR.
- `bus_write_enable` is 0 in every state except WR; `bus_addr` holds its value outside an operation.
- Reset (any time, including mid-operation):
  - FSM goes to IDLE.
  - `bus_write_enable`, `resp_valid`, `resp_fault` go to 0 immediately.
  - `bus_addr`, `bus_write_data`, `resp_data` go to 0.
  - Any in-flight request is dropped.
- Reset value of `req_ready` is 1.

## Timing
- Latencies, from the acceptance edge (cycle 0) to `resp_valid`:
  - Load: `resp_valid` in cycle 3.
  - Double store: WR in cycle 1, `resp_valid` in cycle 2.
  - Sub-double store: WR in cycle 3, `resp_valid` in cycle 4.
  - Fault: `resp_valid` in cycle 1, with no bus activity.
- Bus read: `bus_addr` is stable for RD_ADDR and RD_DATA, two cycles; data is sampled at the end of the second.
- Back-pressure: `resp_valid` and `resp_data` stay stable while `resp_ready` = 0.
- Throughput: the next request can be accepted in the cycle after the RESP handshake.

## Configuration
- Macro: `LSU_FAULT_EN`.
- Defined:
  - A misaligned request faults (offset not a multiple of n).
  - A store with `req_addr[8]` = 0 faults (ex space is read-only).
  - A faulting request sets `resp_fault` = 1 and `resp_data` = 0, and never touches the bus.
- Undefined:
  - The offset is forced to alignment (low log2(n) bits cleared).
  - Stores to ex space run the normal bus sequence, which `io_bus` ignores.
  - `resp_fault` is tied to 0.

## Test plan
- Signed byte load: memory word 0x0011223344556677 at addr 0x100, load size 0, offset 7, signed = 1 → `resp_data` = 0x0000000000000077, valid in cycle 3. Offset 0 with word 0x8000000000000000 → `resp_data` = 0xFFFFFFFFFFFFFF80.
- Half store: word 0x0011223344556677, half store offset 2 with wdata 0xBEEF → exactly one WR cycle writing 0x0011BEEF44556677, `resp_valid` in cycle 4.
- Double store: double store of 0xDEADBEEFCAFEF00D → WR in cycle 1 with no preceding read, response in cycle 2.
- Back-pressure: `resp_ready` held low for 5 cycles → `resp_valid`/`resp_data` stable, `req_ready` = 0. Release → next request accepted the following cycle.
- Fault cases (`LSU_FAULT_EN`): word load at offset 2, or a store to addr 0x005 → `resp_fault` = 1 in cycle 1, `bus_write_enable` never asserted. Without the macro, the same load returns bytes 0..3.
- Reset mid-operation: `rst` asserted low during WR → `bus_write_enable` drops within the same cycle, `req_ready` = 1 after release, memory unchanged if reset precedes the WR edge.
